axi_burst_beat_gen: RTL and testbench
=====================================

# axi_burst_beat_gen

Converts one accepted AXI address-channel request (AW or AR) into a stream of per-beat descriptors. Each descriptor carries the beat address, the byte-lane window, the beat index and a last flag. The block sits directly downstream of the AXI slave address channel and upstream of the UART register-file access logic. It applies the burst arithmetic defined in `axi_pkg` (FIXED/INCR/WRAP, narrow and unaligned transfers) one beat per handshake.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of request and beat addresses
- DATA_WIDTH, 32, AXI data width; STRB_W = DATA_WIDTH/8, LANE_W = $clog2(STRB_W)

Ports:
- clk_i  in  1  clock; all logic is rising-edge
- rst_ni  in  1  synchronous, active-low reset, sampled on the rising edge of clk_i
- ax_addr_i  in  ADDR_WIDTH  request start address
- ax_len_i  in  8  beats minus one (axi_pkg::len_t)
- ax_size_i  in  3  bytes per beat = 1<<size (axi_pkg::size_t)
- ax_burst_i  in  2  axi_pkg::burst_t
- ax_valid_i  in  1  request valid
- ax_ready_o  out  1  request accepted when valid&&ready
- beat_addr_o  out  ADDR_WIDTH  address of current beat
- beat_lower_o  out  LANE_W  lowest active byte lane
- beat_upper_o  out  LANE_W  highest active byte lane
- beat_idx_o  out  8  beat number, 0..len
- beat_last_o  out  1  current beat is beat len
- beat_err_o  out  1  request was illegal; every beat of the request carries it
- beat_valid_o  out  1  descriptor valid
- beat_ready_i  in  1  consumer accepts the descriptor
- busy_o  out  1  a burst is in progress

## Operation
- The FSM has two states, IDLE and BURST.
- IDLE:
  - ax_ready_o=1.
  - On handshake, register addr/len/size/burst and the error flag, clear the beat counter, and go to BURST.
- BURST:
  - beat_valid_o=1.
  - On beat handshake, the counter increments.
  - On the handshake with beat_last_o=1, return to IDLE.
  - Back-to-back: ax_ready_o is also 1 in the cycle where the last beat handshakes. A request accepted in that cycle loads directly, and the FSM stays in BURST.
- Beat address, identical to axi_pkg::beat_addr:
  - Beat 0 = ax_addr, unaligned allowed.
  - For i>0 with FIXED: ax_addr.
  - For i>0 with INCR/WRAP: aligned(ax_addr,size) + i·(1<<size).
  - WRAP: if the result is at or above wrap_boundary + (len+1)·(1<<size), subtract (len+1)·(1<<size).
  - All sums are modulo 2^ADDR_WIDTH.
- Lanes:
  - lower = beat_addr mod STRB_W.
  - Beat 0 upper = (aligned(ax_addr,size) mod STRB_W) + (1<<size) − 1.
  - Beat i>0 upper = lower + (1<<size) − 1.
- Errors are latched at accept. Any one of the following sets the error flag:
  - burst=2'b11;
  - WRAP with len not in {1,3,7,15};
  - (1<<size) > STRB_W;
  - INCR whose last beat crosses a 4 KiB boundary.
- An erroneous request still produces len+1 beats, using the normal arithmetic with burst forced to INCR, and beat_err_o=1 on every beat. This lets the consumer issue SLVERR per beat.

## Timing
- Reset (rst_ni=0 at a clock edge): state IDLE, counter 0, all registered fields 0.
- While rst_ni is low: ax_ready_o=0, beat_valid_o=0, busy_o=0.
- All beat_* outputs are 0 in IDLE.
- Latency: request handshake in cycle N, beat 0 valid in cycle N+1.
- With beat_ready_i held high, one beat per cycle. A burst of len+1 beats occupies cycles N+1..N+1+len.
- Beat outputs are registered or derived only from registers. They stay stable while beat_valid_o && !beat_ready_i.
- Deasserting ax_valid_i while ax_ready_o=0 is legal and has no effect.
- ax_ready_o depends combinationally on beat_ready_i only in the last-beat cycle. The path is one AND gate; there is no ax→beat combinational path.
- Reset asserted mid-burst: remaining beats are dropped and IDLE is entered at that edge.
- len=0: a single beat with beat_last_o=1 in cycle N+1.

## Structure
Additions to axi_pkg:
- typedef beat_desc_t: packed {addr, lower, upper, idx, last, err}.
- function legal_ax(addr,size,len,burst,strb_w) returning the error flag.
- Reuse of the existing beat_addr/beat_lower_byte/beat_upper_byte semantics.

One sub-module, axi_beat_lane_calc:
- Purely combinational.
- Inputs: registered request plus beat index.
- Outputs: addr, lower and upper lanes.
- Unit-tested separately against the package functions.

## Test plan
- INCR, addr 0x1004, size 2, len 3, beat_ready_i=1 -> addrs 0x1004/08/0C/10, lanes 0..3, last on beat 3 only, beat 0 in cycle N+1.
- WRAP, addr 0x38, size 2, len 3 -> addrs 0x38, 0x3C, 0x30, 0x34, beat_err_o=0.
- Unaligned narrow INCR, addr 0x03, size 1, len 1, DATA_WIDTH 32 -> beat0 addr 0x03 lower 3 upper 3; beat1 addr 0x04 lower 0 upper 1.
- Illegal cases:
  - WRAP len 2 -> 3 beats, all with beat_err_o=1.
  - INCR addr 0xFFC, size 2, len 1 -> error because it crosses 4 KiB.
  - burst 2'b11 -> error.
- Backpressure and back-to-back:
  - Toggle beat_ready_i randomly -> outputs are stable while stalled.
  - Second request valid during the last beat -> accepted in that cycle, its beat 0 in the next cycle with no bubble.
- Assert rst_ni=0 during beat 2 of len 7 -> next cycle beat_valid_o=0 and busy_o=0; ax_ready_o=1 after release.

Source files
------------

// File: rtl/axi_burst_beat_gen_pkg.sv
// Burst arithmetic types and helpers shared by the beat generator and its lane calculator.
package axi_burst_beat_gen_pkg;

    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    localparam int unsigned DESC_ADDR_W = 32;
    localparam int unsigned DESC_LANE_W = 2;

    // Descriptor view for the default 32-bit address / 32-bit data configuration.
    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_LANE_W-1:0] lower;
        logic [DESC_LANE_W-1:0] upper;
        len_t                   idx;
        logic                   last;
        logic                   err;
    } beat_desc_t;

    // Returns 1 when the request is illegal. Only the in-page offset of the
    // address matters for the 4 KiB crossing test.
    function automatic logic legal_ax(input logic [11:0] addr, input size_t size,
                                      input len_t len, input burst_t burst,
                                      input int unsigned strb_w);
        logic [11:0] aligned_lo;
        logic [15:0] last_off;
        logic        err;
        aligned_lo = addr & ~((12'd1 << size) - 12'd1);
        last_off   = {4'b0, aligned_lo} + (16'(len) << size);
        err        = 1'b0;
        if (burst == BURST_RSVD) err = 1'b1;
        if (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            err = 1'b1;
        if ((32'd1 << size) > strb_w) err = 1'b1;
        if (burst == BURST_INCR && last_off[15:12] != 4'd0) err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/axi_burst_beat_gen_lane_calc.sv
// Combinational beat address and byte-lane window for one beat of a registered request.
module axi_beat_lane_calc
    import axi_burst_beat_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W = DATA_WIDTH / 8,
    localparam int LANE_W = $clog2(STRB_W)
) (
    input  logic [ADDR_WIDTH-1:0] ax_addr,
    input  len_t                  ax_len,
    input  size_t                 ax_size,
    input  burst_t                ax_burst,
    input  len_t                  idx,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LANE_W-1:0]     lower,
    output logic [LANE_W-1:0]     upper
);
    localparam int AW1 = ADDR_WIDTH + 1;

    // One spare bit so the wrap upper bound cannot overflow at the top of memory.
    logic [AW1-1:0] bytes, aligned, incr, wrap_sz, wrap_lo;

    always_comb begin
        bytes   = AW1'(1) << ax_size;
        aligned = {1'b0, ax_addr} & ~(bytes - AW1'(1));
        incr    = aligned + (AW1'(idx) << ax_size);
        wrap_sz = (AW1'(ax_len) + AW1'(1)) << ax_size;
        wrap_lo = {1'b0, ax_addr} & ~(wrap_sz - AW1'(1));
        addr    = ax_addr;
        if (idx != 8'd0 && ax_burst != BURST_FIXED) begin
            if (ax_burst == BURST_WRAP && incr >= wrap_lo + wrap_sz)
                addr = ADDR_WIDTH'(incr - wrap_sz);
            else
                addr = ADDR_WIDTH'(incr);
        end
        lower = addr[LANE_W-1:0];
        upper = ((idx == 8'd0) ? aligned[LANE_W-1:0] : lower) + LANE_W'(bytes - AW1'(1));
    end

endmodule

// File: rtl/axi_burst_beat_gen.sv
// Expands one accepted AXI address request into a stream of per-beat descriptors.
module axi_burst_beat_gen
    import axi_burst_beat_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W = DATA_WIDTH / 8,
    localparam int LANE_W = $clog2(STRB_W)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] ax_addr_i,
    input  logic [7:0]            ax_len_i,
    input  logic [2:0]            ax_size_i,
    input  logic [1:0]            ax_burst_i,
    input  logic                  ax_valid_i,
    output logic                  ax_ready_o,
    output logic [ADDR_WIDTH-1:0] beat_addr_o,
    output logic [LANE_W-1:0]     beat_lower_o,
    output logic [LANE_W-1:0]     beat_upper_o,
    output logic [7:0]            beat_idx_o,
    output logic                  beat_last_o,
    output logic                  beat_err_o,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic                  busy_o
);
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    len_t                  r_len, cnt;
    size_t                 r_size;
    burst_t                r_burst;
    logic                  r_err;

    logic                  in_burst, last, beat_hs, ax_rdy, accept, req_err;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [LANE_W-1:0]     calc_lower, calc_upper;

    assign in_burst = (state == S_BURST);
    assign last     = in_burst && (cnt == r_len);
    assign beat_hs  = in_burst && beat_ready_i;
    assign accept   = ax_valid_i && ax_ready_o;
    assign req_err  = legal_ax(ax_addr_i[11:0], ax_size_i, ax_len_i, burst_t'(ax_burst_i), STRB_W);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ax_rdy    = 1'b0;
        case (state)
            S_IDLE: begin
                ax_rdy = 1'b1;
                if (ax_valid_i) state_nxt = S_BURST;
            end
            S_BURST: begin
                // Last-beat handshake frees the slot for a back-to-back request.
                if (beat_hs && last) begin
                    ax_rdy    = 1'b1;
                    state_nxt = ax_valid_i ? S_BURST : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= BURST_FIXED;
            r_err   <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            r_addr  <= ax_addr_i;
            r_len   <= ax_len_i;
            r_size  <= ax_size_i;
            // Illegal requests still walk len+1 beats with plain INCR arithmetic.
            r_burst <= req_err ? BURST_INCR : burst_t'(ax_burst_i);
            r_err   <= req_err;
            cnt     <= '0;
        end else if (beat_hs) begin
            cnt <= cnt + 8'd1;
        end
    end

    axi_beat_lane_calc #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_calc (
        .ax_addr (r_addr),
        .ax_len  (r_len),
        .ax_size (r_size),
        .ax_burst(r_burst),
        .idx     (cnt),
        .addr    (calc_addr),
        .lower   (calc_lower),
        .upper   (calc_upper)
    );

    assign ax_ready_o   = rst_ni && ax_rdy;
    assign beat_valid_o = rst_ni && in_burst;
    assign busy_o       = rst_ni && in_burst;
    assign beat_addr_o  = in_burst ? calc_addr  : '0;
    assign beat_lower_o = in_burst ? calc_lower : '0;
    assign beat_upper_o = in_burst ? calc_upper : '0;
    assign beat_idx_o   = in_burst ? cnt        : '0;
    assign beat_last_o  = last;
    assign beat_err_o   = in_burst && r_err;

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Scoreboard bench: directed cases with hand-derived beats plus random requests against a plain arithmetic model.
module tb_axi_burst_beat_gen;
    localparam int STRB = 4;

    logic        clk, rst_ni;
    logic [31:0] ax_addr;
    logic [7:0]  ax_len;
    logic [2:0]  ax_size;
    logic [1:0]  ax_burst;
    logic        ax_valid, ax_ready;
    logic [31:0] beat_addr;
    logic [1:0]  beat_lower, beat_upper;
    logic [7:0]  beat_idx;
    logic        beat_last, beat_err, beat_valid, beat_ready, busy;

    axi_burst_beat_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ax_addr_i(ax_addr), .ax_len_i(ax_len), .ax_size_i(ax_size), .ax_burst_i(ax_burst),
        .ax_valid_i(ax_valid), .ax_ready_o(ax_ready),
        .beat_addr_o(beat_addr), .beat_lower_o(beat_lower), .beat_upper_o(beat_upper),
        .beat_idx_o(beat_idx), .beat_last_o(beat_last), .beat_err_o(beat_err),
        .beat_valid_o(beat_valid), .beat_ready_i(beat_ready), .busy_o(busy)
    );

    typedef struct {
        logic [31:0] addr;
        int          lo, up, idx;
        bit          last, err;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    bit   ready_rand = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input int lo, input int up, input int idx,
                             input bit last, input bit err);
        exp_t e;
        e.addr = a; e.lo = lo; e.up = up; e.idx = idx; e.last = last; e.err = err;
        q.push_back(e);
    endtask

    // Reference burst walk in unbounded integer arithmetic.
    task automatic push_model(input logic [31:0] addr, input int len, input int size, input int burst);
        longint bytes, aligned, a, ws, wb;
        bit     err;
        int     eb, lo;
        bytes   = longint'(1) << size;
        aligned = (longint'(addr) / bytes) * bytes;
        err = (burst == 3) || (bytes > STRB) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (burst == 1 && ((aligned + len * bytes) >> 12) != (longint'(addr) >> 12));
        eb = err ? 1 : burst;
        for (int i = 0; i <= len; i++) begin
            if (i == 0 || eb == 0) a = longint'(addr);
            else begin
                a = aligned + i * bytes;
                if (eb == 2) begin
                    ws = (len + 1) * bytes;
                    wb = (longint'(addr) / ws) * ws;
                    if (a >= wb + ws) a = a - ws;
                end
            end
            a  = a % (longint'(1) << 32);
            lo = int'(a % STRB);
            push_beat(a[31:0], lo, int'(((i == 0 ? aligned % STRB : longint'(lo)) + bytes - 1) % STRB),
                      i, i == len, err);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    logic [31:0] p_addr;
    logic [1:0]  p_lo, p_up;
    logic [7:0]  p_idx;
    logic        p_last, p_err;
    bit          p_stall = 0;

    always @(negedge clk) begin
        if (!rst_ni) begin
            check("rst_valid", beat_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_ax_ready", ax_ready, 0);
            q.delete();
            p_stall = 0;
        end else begin
            if (p_stall) begin
                check("stall_valid", beat_valid, 1);
                check("stall_addr", beat_addr, p_addr);
                check("stall_lanes", {beat_lower, beat_upper}, {p_lo, p_up});
                check("stall_idx", {beat_idx, beat_last, beat_err}, {p_idx, p_last, p_err});
            end
            if (beat_valid) begin
                check("busy_in_burst", busy, 1);
                check("ax_ready_in_burst", ax_ready, beat_last && beat_ready);
                if (beat_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("beat_addr", beat_addr, e.addr);
                        check("beat_lower", beat_lower, e.lo);
                        check("beat_upper", beat_upper, e.up);
                        check("beat_idx", beat_idx, e.idx);
                        check("beat_last", beat_last, e.last);
                        check("beat_err", beat_err, e.err);
                    end
                end
            end else begin
                check("idle_busy", busy, 0);
                check("idle_ax_ready", ax_ready, 1);
                check("idle_outputs", {beat_addr, beat_lower, beat_upper, beat_idx, beat_last, beat_err}, 0);
            end
            p_stall = beat_valid && !beat_ready;
            p_addr = beat_addr; p_lo = beat_lower; p_up = beat_upper;
            p_idx = beat_idx; p_last = beat_last; p_err = beat_err;
        end
    end

    initial begin
        beat_ready = 1;
        forever begin
            @(posedge clk);
            #1 beat_ready = ready_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Raises a request and returns at the falling edge where its handshake is seen.
    task automatic send_req(input logic [31:0] addr, input int len, input int size,
                            input int burst, input bit use_model);
        int n = 0;
        @(posedge clk);
        #1;
        ax_addr = addr; ax_len = 8'(len); ax_size = 3'(size); ax_burst = 2'(burst);
        ax_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!ax_ready && n < 300);
        if (!ax_ready) check("ax_accept_timeout", 0, 1);
        else if (use_model) push_model(addr, len, size, burst);
    endtask

    // Beat 0 must be valid in the cycle right after the request handshake.
    task automatic first_check();
        @(posedge clk);
        #1 ax_valid = 0;
        @(negedge clk);
        check("first_beat_latency", {beat_valid, beat_idx}, {1'b1, 8'd0});
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    int lens[8] = '{0, 1, 2, 3, 5, 7, 15, 1};

    initial begin
        rst_ni = 0; ax_valid = 0; ax_addr = 0; ax_len = 0; ax_size = 0; ax_burst = 0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1;

        send_req(32'h1004, 3, 2, 1, 0);
        push_beat(32'h1004, 0, 3, 0, 0, 0); push_beat(32'h1008, 0, 3, 1, 0, 0);
        push_beat(32'h100C, 0, 3, 2, 0, 0); push_beat(32'h1010, 0, 3, 3, 1, 0);
        first_check(); drain();

        send_req(32'h38, 3, 2, 2, 0);
        push_beat(32'h38, 0, 3, 0, 0, 0); push_beat(32'h3C, 0, 3, 1, 0, 0);
        push_beat(32'h30, 0, 3, 2, 0, 0); push_beat(32'h34, 0, 3, 3, 1, 0);
        first_check(); drain();

        send_req(32'h03, 1, 1, 1, 0);
        push_beat(32'h03, 3, 3, 0, 0, 0); push_beat(32'h04, 0, 1, 1, 1, 0);
        first_check(); drain();

        send_req(32'h100, 2, 2, 2, 0);
        push_beat(32'h100, 0, 3, 0, 0, 1); push_beat(32'h104, 0, 3, 1, 0, 1);
        push_beat(32'h108, 0, 3, 2, 1, 1);
        first_check(); drain();

        send_req(32'hFFC, 1, 2, 1, 0);
        push_beat(32'hFFC, 0, 3, 0, 0, 1); push_beat(32'h1000, 0, 3, 1, 1, 1);
        first_check(); drain();

        send_req(32'h20, 1, 0, 3, 0);
        push_beat(32'h20, 0, 0, 0, 0, 1); push_beat(32'h21, 1, 1, 1, 1, 1);
        first_check(); drain();

        send_req(32'h400, 0, 2, 1, 0);
        push_beat(32'h400, 0, 3, 0, 1, 0);
        first_check(); drain();

        // Back-to-back: the second request is accepted on the first's last beat.
        send_req(32'h800, 1, 2, 1, 1); first_check();
        send_req(32'h900, 1, 2, 2, 1); first_check();
        drain();

        ready_rand = 1;
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom % 3 == 0) a[11:0] = 12'hFE0 | 12'($urandom % 32);
            send_req(a, lens[$urandom % 8], int'($urandom % 4), int'($urandom % 4), 1);
            first_check();
            if ($urandom % 3 == 0) drain();
        end
        drain();

        ready_rand = 0;
        send_req(32'h200, 7, 2, 1, 1);
        first_check();
        begin
            int n = 0;
            while (beat_idx != 8'd1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("reach_beat1", beat_idx, 1);
        end
        @(posedge clk);
        #1 rst_ni = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1;
        @(negedge clk);
        check("post_reset_ready", ax_ready, 1);
        check("post_reset_valid", {beat_valid, busy}, 0);

        send_req(32'h3000, 3, 1, 1, 1);
        first_check(); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
